cont_mem_train_ctrl: RTL and testbench
======================================

Name: cont_mem_train_ctrl

Overview:
Sequencer in front of cont_mem, the HDC class-prototype memory. Accepts labelled training hypervectors from the encoder over a valid/ready handshake and holds each one stable. Issues the single-cycle en pulse to cont_mem, waits for its done, and keeps per-class sample counts. Also schedules prototype override loads, and flags a sticky error if cont_mem never returns done.

Parameters:
DIMENSIONS, 10000, hypervector width in bits
CNT_W, 16, width of the per-class sample counters
TIMEOUT, 2048, max cycles in WAIT before abort (must be > DIMENSIONS/PAR_BITS of cont_mem)

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  reset, asynchronous assert, active-low
in_valid  input  1  training sample valid
in_ready  output  1  controller can accept a sample
in_hv  input  DIMENSIONS  training hypervector
in_label  input  1  0 = nonseizure, 1 = seizure
ovr_req  input  1  request prototype override load (level, sampled in IDLE)
ovr_hv_nonseizure  input  DIMENSIONS  override nonseizure prototype
ovr_hv_seizure  input  DIMENSIONS  override seizure prototype
mem_en  output  1  to cont_mem.en
mem_label_override  output  1  to cont_mem.label_override
mem_hv_train  output  DIMENSIONS  to cont_mem.hv_train
mem_label  output  1  to cont_mem.label
mem_override_hv_nonseizure  output  DIMENSIONS  to cont_mem.override_hv_nonseizure
mem_override_hv_seizure  output  DIMENSIONS  to cont_mem.override_hv_seizure
mem_done  input  1  from cont_mem.done
busy  output  1  state != IDLE
op_done  output  1  one-cycle pulse when a train or override op completes
err_timeout  output  1  sticky timeout flag
cnt_nonseizure  output  CNT_W  completed nonseizure trainings
cnt_seizure  output  CNT_W  completed seizure trainings

Behaviour:
- Reset (nrst=0, async) clears the following:
  - state to IDLE
  - every output to 0, including all data registers, counters and err_timeout
  - wait timer to 0
  - Reset mid-operation abandons the op silently: no op_done, no count.
- States are IDLE, ISSUE, OVR, WAIT.
- in_ready = (state==IDLE) && !ovr_req, combinational. ovr_req has priority over in_valid.
- IDLE, ovr_req=1:
  - Capture ovr_hv_* into the mem_override_hv_* registers.
  - Next state OVR.
- IDLE, in_valid && in_ready:
  - Capture in_hv into mem_hv_train and in_label into mem_label.
  - Next state ISSUE.
- ISSUE: mem_en=1 and mem_label_override=0 for exactly one cycle. Next state WAIT.
- OVR:
  - mem_en=1 and mem_label_override=1 for exactly one cycle. Next state WAIT.
  - An internal op_is_ovr bit records that the current op is an override.
- WAIT:
  - Timer starts at 0 on entry and increments each cycle.
  - mem_done is ignored in the cycle mem_en is high, since it is only sampled in WAIT.
  - On the first cycle with mem_done=1: next state IDLE, and op_done pulses on the following cycle, registered.
    - For a train op, increment cnt_seizure if mem_label=1, else cnt_nonseizure.
    - For an override op, clear both counters.
  - If the timer reaches TIMEOUT-1 without mem_done: set err_timeout, go to IDLE, no op_done, no count.
  - If mem_done and timeout occur in the same cycle, done wins.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- err_timeout stays set until nrst. It does not block further operations.
- mem_hv_train, mem_label and mem_override_hv_* hold their value from capture until the next capture. They are stable throughout WAIT.
- mem_en and mem_label_override are registered state decodes and are glitch-free.
- Sample-to-en latency: handshake cycle N, ISSUE (mem_en=1) at cycle N+1. Earliest re-accept is the cycle after done is seen.
- Throughput is 1 sample per (cont_mem latency + 2) cycles.

Test Plan:
- Reset with nrst=0 for 2 cycles → all outputs 0, in_ready=1 once nrst=1 and ovr_req=0.
- Single train: in_hv=0xA5… pattern, in_label=0, cont_mem model returns done 1000 cycles after en → mem_en high exactly 1 cycle at N+1; mem_hv_train stable throughout WAIT; op_done pulse; cnt_nonseizure=1, cnt_seizure=0.
- Back-to-back: in_valid held high with 3 samples, labels 1,0,1 → exactly 3 en pulses, each after the previous done; in_ready low while busy; final cnt_seizure=2, cnt_nonseizure=1.
- ovr_req and in_valid both asserted in IDLE → OVR taken first with mem_en=1 and mem_label_override=1; counters cleared after done; the sample is accepted afterwards.
- mem_done never asserted → err_timeout=1 exactly TIMEOUT cycles after entering WAIT; no op_done; the next sample trains normally with err_timeout still 1.
- nrst pulsed low in WAIT → immediate IDLE with outputs 0; the pending done is ignored.
- With CNT_W=2, train 5 seizure samples → cnt_seizure=3 (saturated).

Source files
------------

// File: rtl/cont_mem_train_ctrl.sv
// Sequencer in front of cont_mem: captures labelled training hypervectors or
// override prototypes, pulses en, waits for done and keeps per-class counts.
module cont_mem_train_ctrl #(
  parameter int unsigned DIMENSIONS = 10000,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT    = 2048
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIMENSIONS-1:0] in_hv,
  input  logic                  in_label,
  input  logic                  ovr_req,
  input  logic [DIMENSIONS-1:0] ovr_hv_nonseizure,
  input  logic [DIMENSIONS-1:0] ovr_hv_seizure,
  output logic                  mem_en,
  output logic                  mem_label_override,
  output logic [DIMENSIONS-1:0] mem_hv_train,
  output logic                  mem_label,
  output logic [DIMENSIONS-1:0] mem_override_hv_nonseizure,
  output logic [DIMENSIONS-1:0] mem_override_hv_seizure,
  input  logic                  mem_done,
  output logic                  busy,
  output logic                  op_done,
  output logic                  err_timeout,
  output logic [CNT_W-1:0]      cnt_nonseizure,
  output logic [CNT_W-1:0]      cnt_seizure
);

  localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_OVR   = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    op_is_ovr_q, op_is_ovr_d;
  logic [DIMENSIONS-1:0]   hv_q, hv_d;
  logic                    lbl_q, lbl_d;
  logic [DIMENSIONS-1:0]   ovr_ns_q, ovr_ns_d;
  logic [DIMENSIONS-1:0]   ovr_s_q, ovr_s_d;
  logic                    en_q, en_d;
  logic                    lo_q, lo_d;
  logic                    op_done_q, op_done_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_ns_q, cnt_ns_d;
  logic [CNT_W-1:0]        cnt_s_q, cnt_s_d;

  assign in_ready                   = (state_q == S_IDLE) && !ovr_req;
  assign busy                       = (state_q != S_IDLE);
  assign mem_en                     = en_q;
  assign mem_label_override         = lo_q;
  assign mem_hv_train               = hv_q;
  assign mem_label                  = lbl_q;
  assign mem_override_hv_nonseizure = ovr_ns_q;
  assign mem_override_hv_seizure    = ovr_s_q;
  assign op_done                    = op_done_q;
  assign err_timeout                = err_q;
  assign cnt_nonseizure             = cnt_ns_q;
  assign cnt_seizure                = cnt_s_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    op_is_ovr_d = op_is_ovr_q;
    hv_d        = hv_q;
    lbl_d       = lbl_q;
    ovr_ns_d    = ovr_ns_q;
    ovr_s_d     = ovr_s_q;
    en_d        = 1'b0;
    lo_d        = 1'b0;
    op_done_d   = 1'b0;
    err_d       = err_q;
    cnt_ns_d    = cnt_ns_q;
    cnt_s_d     = cnt_s_q;

    // en/label_override are registered against the next state so they line
    // up exactly with the ISSUE/OVR cycle without any combinational decode.
    unique case (state_q)
      S_IDLE: begin
        if (ovr_req) begin
          ovr_ns_d    = ovr_hv_nonseizure;
          ovr_s_d     = ovr_hv_seizure;
          op_is_ovr_d = 1'b1;
          en_d        = 1'b1;
          lo_d        = 1'b1;
          state_d     = S_OVR;
        end else if (in_valid) begin
          hv_d        = in_hv;
          lbl_d       = in_label;
          op_is_ovr_d = 1'b0;
          en_d        = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE, S_OVR: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done) begin
          op_done_d = 1'b1;
          state_d   = S_IDLE;
          if (op_is_ovr_q) begin
            cnt_ns_d = '0;
            cnt_s_d  = '0;
          end else if (lbl_q) begin
            if (cnt_s_q != '1) cnt_s_d = cnt_s_q + CNT_W'(1);
          end else begin
            if (cnt_ns_q != '1) cnt_ns_d = cnt_ns_q + CNT_W'(1);
          end
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      op_is_ovr_q <= 1'b0;
      hv_q        <= '0;
      lbl_q       <= 1'b0;
      ovr_ns_q    <= '0;
      ovr_s_q     <= '0;
      en_q        <= 1'b0;
      lo_q        <= 1'b0;
      op_done_q   <= 1'b0;
      err_q       <= 1'b0;
      cnt_ns_q    <= '0;
      cnt_s_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      op_is_ovr_q <= op_is_ovr_d;
      hv_q        <= hv_d;
      lbl_q       <= lbl_d;
      ovr_ns_q    <= ovr_ns_d;
      ovr_s_q     <= ovr_s_d;
      en_q        <= en_d;
      lo_q        <= lo_d;
      op_done_q   <= op_done_d;
      err_q       <= err_d;
      cnt_ns_q    <= cnt_ns_d;
      cnt_s_q     <= cnt_s_d;
    end
  end

endmodule

// File: tb/tb_cont_mem_train_ctrl.sv
// Randomized bench for cont_mem_train_ctrl with a transaction-level model of
// expected counts, captured data, en timing, done/timeout handling and reset.
module tb_cont_mem_train_ctrl;

  localparam int unsigned DIM = 96;
  localparam int unsigned CW  = 2;
  localparam int unsigned TO  = 1100;
  localparam int          CMAX = (1 << CW) - 1;

  logic           clk;
  logic           nrst;
  logic           in_valid;
  logic           in_ready;
  logic [DIM-1:0] in_hv;
  logic           in_label;
  logic           ovr_req;
  logic [DIM-1:0] ovr_hv_nonseizure;
  logic [DIM-1:0] ovr_hv_seizure;
  logic           mem_en;
  logic           mem_label_override;
  logic [DIM-1:0] mem_hv_train;
  logic           mem_label;
  logic [DIM-1:0] mem_override_hv_nonseizure;
  logic [DIM-1:0] mem_override_hv_seizure;
  logic           mem_done;
  logic           busy;
  logic           op_done;
  logic           err_timeout;
  logic [CW-1:0]  cnt_nonseizure;
  logic [CW-1:0]  cnt_seizure;

  cont_mem_train_ctrl #(
    .DIMENSIONS(DIM),
    .CNT_W     (CW),
    .TIMEOUT   (TO)
  ) dut (
    .clk                       (clk),
    .nrst                      (nrst),
    .in_valid                  (in_valid),
    .in_ready                  (in_ready),
    .in_hv                     (in_hv),
    .in_label                  (in_label),
    .ovr_req                   (ovr_req),
    .ovr_hv_nonseizure         (ovr_hv_nonseizure),
    .ovr_hv_seizure            (ovr_hv_seizure),
    .mem_en                    (mem_en),
    .mem_label_override        (mem_label_override),
    .mem_hv_train              (mem_hv_train),
    .mem_label                 (mem_label),
    .mem_override_hv_nonseizure(mem_override_hv_nonseizure),
    .mem_override_hv_seizure   (mem_override_hv_seizure),
    .mem_done                  (mem_done),
    .busy                      (busy),
    .op_done                   (op_done),
    .err_timeout               (err_timeout),
    .cnt_nonseizure            (cnt_nonseizure),
    .cnt_seizure               (cnt_seizure)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int             exp_ns, exp_s;
  logic           exp_err;
  logic [DIM-1:0] exp_hv, exp_ovr_ns, exp_ovr_s;
  logic           exp_lbl;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DIM-1:0] rand_hv();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_ns = 0; exp_s = 0; exp_err = 1'b0;
    exp_hv = '0; exp_lbl = 1'b0; exp_ovr_ns = '0; exp_ovr_s = '0;
  endtask

  task automatic check_static(input string ph);
    chk({ph, ".cnt_ns"}, cnt_nonseizure, exp_ns);
    chk({ph, ".cnt_s"}, cnt_seizure, exp_s);
    chk({ph, ".err"}, err_timeout, exp_err);
    chk({ph, ".hv_train"}, mem_hv_train, exp_hv);
    chk({ph, ".label"}, mem_label, exp_lbl);
    chk({ph, ".ovr_ns"}, mem_override_hv_nonseizure, exp_ovr_ns);
    chk({ph, ".ovr_s"}, mem_override_hv_seizure, exp_ovr_s);
  endtask

  task automatic check_all_zero(input string ph);
    chk({ph, ".en"}, mem_en, 0);
    chk({ph, ".lo"}, mem_label_override, 0);
    chk({ph, ".busy"}, busy, 0);
    chk({ph, ".op_done"}, op_done, 0);
    check_static(ph);
  endtask

  // cont_mem model: done arrives in WAIT cycle 'lat' (lat >= TO means never).
  task automatic wait_phase(input int lat, input bit is_ovr, input bit junk, input bit hold_valid);
    for (int k = 0; k < TO; k++) begin
      cyc();
      chk("wait.en", mem_en, 0);
      chk("wait.lo", mem_label_override, 0);
      chk("wait.busy", busy, 1);
      chk("wait.in_ready", in_ready, 0);
      chk("wait.op_done", op_done, 0);
      if (k < 3 || k % 97 == 0) check_static("wait");
      if (k == lat || k == TO - 1) begin
        mem_done = (k == lat);
        ovr_req  = 1'b0;
        in_valid = hold_valid;
        cyc();
        mem_done = 1'b0;
        if (k == lat) begin
          if (is_ovr) begin
            exp_ns = 0; exp_s = 0;
          end else if (exp_lbl) begin
            exp_s = (exp_s < CMAX) ? exp_s + 1 : CMAX;
          end else begin
            exp_ns = (exp_ns < CMAX) ? exp_ns + 1 : CMAX;
          end
          chk("done.op_done", op_done, 1);
        end else begin
          exp_err = 1'b1;
          chk("tmo.op_done", op_done, 0);
        end
        chk("end.busy", busy, 0);
        check_static("end");
        break;
      end
      mem_done = 1'b0;
      if (junk) begin
        in_hv             = rand_hv();
        in_label          = $urandom_range(0, 1);
        ovr_req           = $urandom_range(0, 1);
        ovr_hv_nonseizure = rand_hv();
        ovr_hv_seizure    = rand_hv();
      end
    end
  endtask

  task automatic do_train(input logic [DIM-1:0] hv, input logic lbl, input int lat, input bit junk);
    in_valid = 1'b1; in_hv = hv; in_label = lbl; ovr_req = 1'b0;
    #1;
    chk("idle.in_ready", in_ready, 1);
    chk("idle.busy", busy, 0);
    cyc();
    exp_hv = hv; exp_lbl = lbl;
    if (junk) begin
      in_hv = rand_hv(); in_label = ~lbl;
      mem_done = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    chk("issue.en", mem_en, 1);
    chk("issue.lo", mem_label_override, 0);
    chk("issue.busy", busy, 1);
    chk("issue.in_ready", in_ready, 0);
    chk("issue.op_done", op_done, 0);
    check_static("issue");
    wait_phase(lat, 1'b0, junk, 1'b0);
  endtask

  task automatic do_ovr(input logic [DIM-1:0] a, input logic [DIM-1:0] b, input int lat,
                        input bit with_valid, input logic [DIM-1:0] pend_hv, input logic pend_lbl);
    ovr_req = 1'b1; ovr_hv_nonseizure = a; ovr_hv_seizure = b;
    in_valid = with_valid; in_hv = pend_hv; in_label = pend_lbl;
    #1;
    chk("ovr_idle.in_ready", in_ready, 0);
    cyc();
    exp_ovr_ns = a; exp_ovr_s = b;
    ovr_req = 1'b0; ovr_hv_nonseizure = rand_hv(); ovr_hv_seizure = rand_hv();
    chk("ovr.en", mem_en, 1);
    chk("ovr.lo", mem_label_override, 1);
    chk("ovr.busy", busy, 1);
    chk("ovr.in_ready", in_ready, 0);
    check_static("ovr");
    wait_phase(lat, 1'b1, 1'b0, with_valid);
  endtask

  task automatic random_ops(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0)
        do_ovr(rand_hv(), rand_hv(), $urandom_range(0, 12), 1'b0, '0, 1'b0);
      else
        do_train(rand_hv(), $urandom_range(0, 1), $urandom_range(0, 12), $urandom_range(0, 1));
    end
  endtask

  initial begin
    logic [DIM-1:0] pend;
    nrst = 1'b0; in_valid = 1'b0; in_hv = '0; in_label = 1'b0; ovr_req = 1'b0;
    ovr_hv_nonseizure = '0; ovr_hv_seizure = '0; mem_done = 1'b0;
    model_reset();
    cyc(); cyc();
    check_all_zero("reset");
    nrst = 1'b1;
    #1;
    chk("reset.in_ready", in_ready, 1);

    // Single train with the A5 pattern, done 1000 cycles after en
    do_train({12{8'hA5}}, 1'b0, 999, 1'b0);
    cyc();
    chk("single.op_done_pulse", op_done, 0);

    // Back-to-back labels 1,0,1 with in_valid held high between samples
    do_train(rand_hv(), 1'b1, $urandom_range(0, 8), 1'b1);
    do_train(rand_hv(), 1'b0, $urandom_range(0, 8), 1'b1);
    do_train(rand_hv(), 1'b1, 0, 1'b1);

    // Override competing with a valid sample: override first, sample after
    pend = rand_hv();
    do_ovr(rand_hv(), rand_hv(), 5, 1'b1, pend, 1'b1);
    do_train(pend, 1'b1, 3, 1'b0);

    // Saturation: 5 seizure samples after clearing
    do_ovr(rand_hv(), rand_hv(), 2, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) do_train(rand_hv(), 1'b1, $urandom_range(0, 4), 1'b0);

    // Done on the very last timer cycle wins over timeout
    do_train(rand_hv(), 1'b0, TO - 1, 1'b0);
    // No done at all: timeout, then normal training with err still set
    do_train(rand_hv(), 1'b1, TO + 10, 1'b0);
    do_train(rand_hv(), 1'b0, 4, 1'b0);

    random_ops(60);

    // Reset in the middle of WAIT; the pending done must be ignored
    in_valid = 1'b1; in_hv = rand_hv(); in_label = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc(); cyc(); cyc();
    nrst = 1'b0;
    model_reset();
    #1;
    check_all_zero("midrst");
    mem_done = 1'b1;
    cyc(); cyc();
    nrst = 1'b1;
    cyc();
    mem_done = 1'b0;
    check_all_zero("postrst");
    chk("postrst.in_ready", in_ready, 1);

    random_ops(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
